// File: rtl/bpred_pkg.sv
// Shared definitions for the branch target buffer: counter states, the
// counter update operations, the lookup entry view and the saturating step.
package bpred_pkg;

  localparam int MAX_PC_W  = 64;
  localparam int MAX_CNT_W = 4;

  // Named states of the classic 2-bit predictor counter.
  localparam logic [1:0] CNT2_SNT = 2'd0;
  localparam logic [1:0] CNT2_WNT = 2'd1;
  localparam logic [1:0] CNT2_WT  = 2'd2;
  localparam logic [1:0] CNT2_ST  = 2'd3;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_INIT = 2'd3
  } cnt_op_e;

  // Fields are sized for the widest configuration; callers zero-extend.
  typedef struct packed {
    logic                 valid;
    logic [MAX_PC_W-1:0]  tag;
    logic [MAX_PC_W-1:0]  target;
    logic [MAX_CNT_W-1:0] cnt;
  } btb_entry_t;

  function automatic logic [MAX_CNT_W-1:0] cnt_sat_step(
    input logic [MAX_CNT_W-1:0] cnt,
    input logic [MAX_CNT_W-1:0] cnt_max,
    input logic                 up
  );
    logic [MAX_CNT_W-1:0] res;
    if (up) begin
      res = (cnt >= cnt_max) ? cnt : cnt + 4'd1;
    end else begin
      res = (cnt == 4'd0) ? cnt : cnt - 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter_array.sv
// Array of saturating prediction counters: one combinational read port and
// one read-modify-write port, cleared by synchronous reset.
module sat_counter_array
  import bpred_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int CNT_W   = 2,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic [IW-1:0]   wr_idx,
  input  cnt_op_e         wr_op
);

  localparam logic [MAX_CNT_W-1:0] CNT_MAX  = MAX_CNT_W'((2 ** CNT_W) - 1);
  localparam logic [CNT_W-1:0]     CNT_WEAK = CNT_W'(2 ** (CNT_W - 1));

  logic [CNT_W-1:0] cnt_r [ENTRIES];
  logic [CNT_W-1:0] wr_cur_s;
  logic [CNT_W-1:0] wr_next_s;

  assign rd_cnt   = cnt_r[rd_idx];
  assign wr_cur_s = cnt_r[wr_idx];

  // Next value of the counter addressed by the write port.
  always_comb begin
    wr_next_s = wr_cur_s;
    case (wr_op)
      CNT_INC:  wr_next_s = CNT_W'(cnt_sat_step(MAX_CNT_W'(wr_cur_s), CNT_MAX, 1'b1));
      CNT_DEC:  wr_next_s = CNT_W'(cnt_sat_step(MAX_CNT_W'(wr_cur_s), CNT_MAX, 1'b0));
      CNT_INIT: wr_next_s = CNT_WEAK;
      default:  wr_next_s = wr_cur_s;
    endcase
  end

  // Counter storage; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (wr_op != CNT_HOLD) begin
      cnt_r[wr_idx] <= wr_next_s;
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Branch target buffer with saturating counters and optional gshare indexing:
// same-cycle prediction for fetch, training and mispredict detection at decode.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int PC_W    = 32,
  parameter  int CNT_W   = 2,
  parameter  int GHR_W   = 0,
  parameter  int STAT_W  = 16,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_f,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  output logic [IW-1:0]     pred_idx,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [IW-1:0]     upd_idx,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_target,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  output logic              mispredict_taken,
  output logic              mispredict_not_taken,
  output logic              mispredict_target,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int TAG_W = PC_W - IW - 2;

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [PC_W-1:0]   target_r [ENTRIES];

  logic [IW-1:0]     hist_idx_s;
  logic [IW-1:0]     lk_idx_s;
  logic [CNT_W-1:0]  lk_cnt_s;
  btb_entry_t        lk_s;
  logic              upd_hit_s;
  logic              mp_any_s;
  cnt_op_e           upd_op_s;

  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr_r;
      // Committed branch history, shifted in at resolution.
      always_ff @(posedge clk) begin
        if (rst) begin
          ghr_r <= '0;
        end else if (upd_valid) begin
          ghr_r <= GHR_W'({ghr_r, upd_taken});
        end
      end
      assign hist_idx_s = IW'(ghr_r);
    end else begin : g_no_ghr
      assign hist_idx_s = '0;
    end
  endgenerate

  assign lk_idx_s = pc_f[IW+1:2] ^ hist_idx_s;
  assign pred_idx = lk_idx_s;

  // Gather the entry addressed by the fetch PC.
  always_comb begin
    lk_s        = '0;
    lk_s.valid  = valid_r[lk_idx_s];
    lk_s.tag    = MAX_PC_W'(tag_r[lk_idx_s]);
    lk_s.target = MAX_PC_W'(target_r[lk_idx_s]);
    lk_s.cnt    = MAX_CNT_W'(lk_cnt_s);
  end

  assign pred_hit    = lk_s.valid && (lk_s.tag == MAX_PC_W'(pc_f[PC_W-1:IW+2]));
  assign pred_taken  = pred_hit && lk_s.cnt[CNT_W-1];
  assign pred_target = pred_hit ? lk_s.target[PC_W-1:0] : '0;

  assign upd_hit_s = valid_r[upd_idx] && (tag_r[upd_idx] == upd_pc[PC_W-1:IW+2]);

  // The three cases are disjoint in (predicted, actual), so at most one fires.
  assign mispredict_taken     = upd_valid && !upd_pred_taken && upd_taken;
  assign mispredict_not_taken = upd_valid && upd_pred_taken && !upd_taken;
  assign mispredict_target    = upd_valid && upd_pred_taken && upd_taken &&
                                (upd_pred_target != upd_target);
  assign mp_any_s = mispredict_taken || mispredict_not_taken || mispredict_target;

  // Counter action for the resolved branch; not-taken misses never allocate.
  always_comb begin
    upd_op_s = CNT_HOLD;
    if (upd_valid) begin
      if (upd_hit_s) begin
        upd_op_s = upd_taken ? CNT_INC : CNT_DEC;
      end else if (upd_taken) begin
        upd_op_s = CNT_INIT;
      end else begin
        upd_op_s = CNT_HOLD;
      end
    end else begin
      upd_op_s = CNT_HOLD;
    end
  end

  sat_counter_array #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (lk_idx_s),
    .rd_cnt (lk_cnt_s),
    .wr_idx (upd_idx),
    .wr_op  (upd_op_s)
  );

  // Valid bits; a taken branch either refreshes a hit or allocates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (upd_valid && upd_taken) begin
      valid_r[upd_idx] <= 1'b1;
    end
  end

  // Tag and target payload, left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      tag_r[upd_idx]    <= upd_pc[PC_W-1:IW+2];
      target_r[upd_idx] <= upd_target;
    end
  end

  // Saturating branch and mispredict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && (stat_branches != '1)) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (mp_any_s && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// Directed bench for bpred_btb: a plain-indexed instance and a gshare
// instance share one stimulus stream; expected values are hand-computed.
module tb_bpred_btb;

  localparam int PC_W   = 32;
  localparam int IW     = 6;
  localparam int STAT_W = 4;

  logic              clk;
  logic              rst;
  logic [PC_W-1:0]   pc_f;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic [IW-1:0]     upd_idx;
  logic              upd_pred_taken;
  logic [PC_W-1:0]   upd_pred_target;
  logic              upd_taken;
  logic [PC_W-1:0]   upd_target;

  logic              p_hit, p_taken, p_mt, p_mnt, p_mtg;
  logic [PC_W-1:0]   p_target;
  logic [IW-1:0]     p_idx;
  logic [STAT_W-1:0] p_br, p_mp;

  logic              g_hit, g_taken, g_mt, g_mnt, g_mtg;
  logic [PC_W-1:0]   g_target;
  logic [IW-1:0]     g_idx;
  logic [STAT_W-1:0] g_br, g_mp;

  int n_checks = 0;
  int n_errors = 0;

  bpred_btb #(.ENTRIES(64), .PC_W(PC_W), .CNT_W(2), .GHR_W(0), .STAT_W(STAT_W)) u_dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_hit(p_hit), .pred_taken(p_taken), .pred_target(p_target), .pred_idx(p_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .mispredict_taken(p_mt), .mispredict_not_taken(p_mnt), .mispredict_target(p_mtg),
    .stat_branches(p_br), .stat_mispredicts(p_mp)
  );

  bpred_btb #(.ENTRIES(64), .PC_W(PC_W), .CNT_W(2), .GHR_W(4), .STAT_W(STAT_W)) u_gs (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_target), .pred_idx(g_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .mispredict_taken(g_mt), .mispredict_not_taken(g_mnt), .mispredict_target(g_mtg),
    .stat_branches(g_br), .stat_mispredicts(g_mp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a fetch PC with no update and check the prediction at the negedge.
  task automatic look(input string tag, input logic [PC_W-1:0] pc,
                      input logic exp_hit, input logic exp_taken,
                      input logic [PC_W-1:0] exp_tgt);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    pc_f      = pc;
    @(negedge clk);
    chk({tag, "_hit"}, 64'(p_hit), 64'(exp_hit));
    chk({tag, "_taken"}, 64'(p_taken), 64'(exp_taken));
    chk({tag, "_target"}, 64'(p_target), 64'(exp_tgt));
  endtask

  // One resolved branch; exp_mp is {taken, not_taken, target}.
  task automatic upd(input string tag, input logic [PC_W-1:0] pc,
                     input logic ptak, input logic [PC_W-1:0] ptgt,
                     input logic tak, input logic [PC_W-1:0] tgt,
                     input logic [2:0] exp_mp);
    @(posedge clk); #1;
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_idx         = pc[IW+1:2];
    upd_pred_taken  = ptak;
    upd_pred_target = ptgt;
    upd_taken       = tak;
    upd_target      = tgt;
    @(negedge clk);
    chk({tag, "_mp"}, 64'({p_mt, p_mnt, p_mtg}), 64'(exp_mp));
  endtask

  initial begin
    rst = 1'b1; pc_f = 32'h40; upd_valid = 1'b0; upd_pc = 32'h0; upd_idx = 6'd0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cold start
    look("cold", 32'h40, 1'b0, 1'b0, 32'h0);
    chk("cold_mp_idle", 64'({p_mt, p_mnt, p_mtg}), 64'd0);
    chk("cold_idx", 64'(p_idx), 64'd16);
    chk("cold_br", 64'(p_br), 64'd0);
    chk("cold_mpcnt", 64'(p_mp), 64'd0);
    upd("alloc", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 3'b100);
    look("alloc_look", 32'h40, 1'b1, 1'b1, 32'h100);
    chk("alloc_br", 64'(p_br), 64'd1);
    chk("alloc_mpcnt", 64'(p_mp), 64'd1);

    // Saturation: count climbs to ST, then steps down and holds at SNT
    for (int i = 0; i < 10; i++) upd("sat_up", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 3'b000);
    upd("sat_nt1", 32'h40, 1'b1, 32'h100, 1'b0, 32'h100, 3'b010);
    look("st_to_wt", 32'h40, 1'b1, 1'b1, 32'h100);
    upd("sat_nt2", 32'h40, 1'b1, 32'h100, 1'b0, 32'h100, 3'b010);
    look("wt_to_wnt", 32'h40, 1'b1, 1'b0, 32'h100);
    upd("sat_nt3", 32'h40, 1'b0, 32'h100, 1'b0, 32'h100, 3'b000);
    upd("sat_nt4", 32'h40, 1'b0, 32'h100, 1'b0, 32'h100, 3'b000);
    upd("sat_t1", 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 3'b100);
    look("floor_held", 32'h40, 1'b1, 1'b0, 32'h100);
    upd("sat_t2", 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 3'b100);
    look("back_to_wt", 32'h40, 1'b1, 1'b1, 32'h100);
    chk("br_saturated", 64'(p_br), 64'd15);
    chk("sat_mpcnt", 64'(p_mp), 64'd5);

    // Target change
    upd("tgt_chg", 32'h40, 1'b1, 32'h100, 1'b1, 32'h200, 3'b001);
    look("tgt_new", 32'h40, 1'b1, 1'b1, 32'h200);

    // Aliasing on index 16
    upd("alias_nt", 32'h1040, 1'b0, 32'h0, 1'b0, 32'h300, 3'b000);
    look("alias_keep", 32'h40, 1'b1, 1'b1, 32'h200);
    look("alias_miss", 32'h1040, 1'b0, 1'b0, 32'h0);
    upd("alias_t", 32'h1040, 1'b0, 32'h0, 1'b1, 32'h300, 3'b100);
    look("alias_evicted", 32'h40, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h1040, 1'b1, 1'b1, 32'h300);
    chk("alias_mpcnt", 64'(p_mp), 64'd7);

    // Reset concurrent with an update
    @(posedge clk); #1;
    rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h80; upd_idx = 6'd32;
    upd_pred_taken = 1'b0; upd_taken = 1'b1; upd_target = 32'h700;
    @(posedge clk); #1;
    rst = 1'b0; upd_valid = 1'b0;
    look("rst_40", 32'h40, 1'b0, 1'b0, 32'h0);
    chk("rst_gidx", 64'(g_idx), 64'd16);
    look("rst_1040", 32'h1040, 1'b0, 1'b0, 32'h0);
    look("rst_80", 32'h80, 1'b0, 1'b0, 32'h0);
    chk("rst_br", 64'(p_br), 64'd0);
    chk("rst_mpcnt", 64'(p_mp), 64'd0);

    // Gshare history T,T,N
    upd("gs_t1", 32'h80, 1'b1, 32'h500, 1'b1, 32'h500, 3'b000);
    upd("gs_t2", 32'h80, 1'b1, 32'h500, 1'b1, 32'h500, 3'b000);
    upd("gs_n", 32'h80, 1'b0, 32'h500, 1'b0, 32'h500, 3'b000);
    look("gs_look", 32'h40, 1'b0, 1'b0, 32'h0);
    chk("gs_idx", 64'(g_idx), 64'd22);
    chk("plain_idx", 64'(p_idx), 64'd16);
    chk("gs_br", 64'(p_br), 64'd3);
    chk("gs_mpcnt", 64'(p_mp), 64'd0);

    // Mispredict counter saturation: 2^STAT_W + 3 mispredicts
    for (int i = 0; i < 19; i++) upd("storm", 32'hC0, 1'b0, 32'h0, 1'b1, 32'h600, 3'b100);
    look("storm_look", 32'hC0, 1'b1, 1'b1, 32'h600);
    chk("mp_saturated", 64'(p_mp), 64'd15);
    chk("br_saturated2", 64'(p_br), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bpred_btb.md
# bpred_btb

Parametrised branch target buffer with per-entry saturating counters and optional gshare indexing. It sits beside the fetch stage: it gives a same-cycle taken/target prediction for `pc_f`. It is trained from the decode stage, where branches resolve, and reports mispredictions so hazard logic can redirect fetch. It adds allocate-on-taken, configurable counter width, global history and misprediction statistics.

## Interface
- `ENTRIES`, 64: number of BTB entries; power of two, ≥ 4.
- `PC_W`, 32: PC width.
- `CNT_W`, 2: saturating counter width, 1..4.
- `GHR_W`, 0: global history bits; 0 selects plain PC indexing; must be ≤ log2(ENTRIES).
- `STAT_W`, 16: width of the statistics counters.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `pc_f  in  PC_W`: fetch PC.
- `pred_hit  out  1`: valid entry with a matching tag at the lookup index.
- `pred_taken  out  1`: `pred_hit` and counter MSB = 1.
- `pred_target  out  PC_W`: stored target; drives the fetch PC mux when `pred_taken`.
- `pred_idx  out  log2(ENTRIES)`: lookup index; the pipeline carries it to decode.
- `upd_valid  in  1`: a branch is resolved in decode this cycle.
- `upd_pc  in  PC_W`: PC of the resolved branch.
- `upd_idx  in  log2(ENTRIES)`: `pred_idx` captured when the branch was fetched.
- `upd_pred_taken  in  1`: `pred_taken` captured at fetch.
- `upd_pred_target  in  PC_W`: `pred_target` captured at fetch.
- `upd_taken  in  1`: actual branch outcome.
- `upd_target  in  PC_W`: actual branch target.
- `mispredict_taken  out  1`: predicted not-taken, actually taken; redirect to `upd_target`.
- `mispredict_not_taken  out  1`: predicted taken, actually not taken; redirect to `upd_pc`+4.
- `mispredict_target  out  1`: predicted and actually taken, but `upd_pred_target` ≠ `upd_target`.
- `stat_branches  out  STAT_W`: resolved branches counted since reset.
- `stat_mispredicts  out  STAT_W`: mispredictions counted since reset.

## Operation
- Fields:
  - IW = log2(ENTRIES).
  - Tag = `pc[PC_W-1:IW+2]`.
  - PC index = `pc[IW+1:2]`.
  - Lookup index = PC index XOR {zeros, `ghr`} when GHR_W > 0, else PC index.
- Entry contents: `valid`, `tag`, `target`, `cnt[CNT_W-1:0]`.
- Lookup:
  - Purely combinational from `pc_f` and the registered `ghr`.
  - On a miss, `pred_target` = 0, `pred_taken` = 0.
- Mispredict outputs:
  - Combinational and gated by `upd_valid`.
  - At most one is asserted per cycle.
- Update, on the clock edge when `upd_valid`, written to entry `upd_idx`:
  - Hit (valid and tag match): the counter saturates up if `upd_taken`, down otherwise; target ← `upd_target` if `upd_taken`.
  - Miss and `upd_taken`: allocate or overwrite the entry with valid=1, tag, target, cnt = 2^(CNT_W-1) (weakly taken).
  - Miss and not taken: no write.
- Counter saturation: it never wraps past 0 or 2^CNT_W-1.
- History: when `upd_valid`, `ghr` ← {`ghr[GHR_W-2:0]`, `upd_taken`}. History is non-speculative; the pipeline flushes on every mispredict.
- Statistics:
  - `stat_branches` increments on `upd_valid`.
  - `stat_mispredicts` increments when any mispredict output is asserted.
  - Both saturate at all-ones.
- Reset: all `valid` ← 0, all counters ← 0, `ghr` ← 0, statistics ← 0. Targets and tags need not be reset. Reset overrides a concurrent update.

## Timing
- Prediction latency is 0 cycles (same-cycle combinational). Update latency is 1 cycle: the written entry is visible to lookup on the next cycle.
- Same-cycle lookup and update to one index: the lookup sees the old contents (no bypass).
- Outputs after reset:
  - `pred_hit` = `pred_taken` = 0; `pred_target` = 0.
  - Mispredict outputs = 0 while `upd_valid` = 0.
  - Statistics = 0.
- Tag aliasing: two branches with the same index overwrite each other only on a taken allocate; a not-taken miss never evicts.
- No handshake: `upd_valid` is a single-cycle strobe, one branch per cycle maximum.

## Structure
- A shared package `bpred_pkg` holds:
  - A counter-state localparam set (for CNT_W=2: SNT=0, WNT=1, WT=2, ST=3).
  - A saturating inc/dec function.
  - An entry struct typedef.
- One sub-module, `sat_counter_array`: ENTRIES×CNT_W counters with one read port, one read-modify-write port and synchronous reset. Tag, target and valid storage stays in the top level.

## Test plan
- Cold start: reset, `pc_f`=0x40 → `pred_hit`=0, `pred_taken`=0. Then `upd_valid` with `upd_pc`=0x40, taken, target 0x100, `upd_pred_taken`=0 → `mispredict_taken`=1 that cycle. The next cycle, `pc_f`=0x40 → hit, taken, target 0x100.
- Saturation: ten taken updates to 0x40 then one not-taken → `pred_taken` stays 1 (ST→WT). A second not-taken → `pred_taken`=0. Further not-taken updates hold the counter at 0.
- Target change: entry at 0x40 holds target 0x100; update taken with `upd_pred_target`=0x100 and `upd_target`=0x200 → `mispredict_target`=1. The next lookup returns 0x200.
- Aliasing (ENTRIES=64): 0x40 allocated; not-taken miss from 0x1040 → entry unchanged. Taken update from 0x1040 → 0x40 misses, 0x1040 hits.
- Gshare (GHR_W=4): updates taken, taken, not-taken → `ghr`=4'b0110. `pc_f`=0x40 → `pred_idx` = 16 XOR 6 = 22.
- Reset mid-run and statistics: reset asserted together with `upd_valid` → no write occurs, statistics and `ghr` = 0, all lookups miss. Drive 2^STAT_W+3 mispredicts → `stat_mispredicts` saturates at all-ones.
